des_subkey_gen: RTL and testbench

Iterative DES key schedule. Accepts a 64-bit key and streams the sixteen 48-bit round subkeys over a valid/ready handshake. Subkeys come out in forward order (K1..K16) for encryption or reverse order (K16..K1) for decryption. It feeds the key side of the round XOR whose 48-bit result drives `s_function`. `subkey[47:42]` is the S1 field, matching `s_function` `in[47:42]`.

---
 rtl/des_subkey_gen.sv | 132 +++++++++++++
 tb/tb_des_subkey_gen.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_subkey_gen.sv
// rtl/des_subkey_gen.sv - iterative DES key schedule streaming K1..K16 or K16..K1

module des_subkey_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  key_index,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_next;
  logic [27:0] c_reg, d_reg;
  logic [3:0]  n;
  logic        mode;
  logic        done_q;
  logic        hs;
  logic        last_hs;
  logic        single_step;
  logic [55:0] pc1_key;

  // PC-1: DES bit b of the key lives at key[64-b]; cd[55] is PC-1 position 1.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    pc1 = {k[7],  k[15], k[23], k[31], k[39], k[47], k[55],
           k[63], k[6],  k[14], k[22], k[30], k[38], k[46],
           k[54], k[62], k[5],  k[13], k[21], k[29], k[37],
           k[45], k[53], k[61], k[4],  k[12], k[20], k[28],
           k[1],  k[9],  k[17], k[25], k[33], k[41], k[49],
           k[57], k[2],  k[10], k[18], k[26], k[34], k[42],
           k[50], k[58], k[3],  k[11], k[19], k[27], k[35],
           k[43], k[51], k[59], k[36], k[44], k[52], k[60]};
  endfunction

  // PC-2: position p of {C,D} lives at cd[56-p]; result[47] is subkey bit 1.
  function automatic logic [47:0] pc2(input logic [55:0] cd);
    pc2 = {cd[42], cd[39], cd[45], cd[32], cd[55], cd[51],
           cd[53], cd[28], cd[41], cd[50], cd[35], cd[46],
           cd[33], cd[37], cd[44], cd[52], cd[30], cd[48],
           cd[40], cd[49], cd[29], cd[36], cd[43], cd[54],
           cd[15], cd[4],  cd[25], cd[19], cd[9],  cd[1],
           cd[26], cd[16], cd[5],  cd[11], cd[23], cd[8],
           cd[12], cd[7],  cd[17], cd[0],  cd[22], cd[3],
           cd[10], cd[14], cd[6],  cd[20], cd[27], cd[24]};
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] v, input logic one);
    rotl = one ? {v[26:0], v[27]} : {v[25:0], v[27:26]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] v, input logic one);
    rotr = one ? {v[0], v[27:1]} : {v[1:0], v[27:2]};
  endfunction

  assign pc1_key = pc1(key);
  assign hs      = (state == RUN) && subkey_ready;
  assign last_hs = hs && (n == 4'd15);

  // Rounds with a single-bit shift (1, 2, 9, 16) fall on n = 0, 7, 14 in both
  // directions: forward uses shift[n+2], reverse uses shift[16-n].
  assign single_step = (n == 4'd0) || (n == 4'd7) || (n == 4'd14);

  assign subkey       = pc2({c_reg, d_reg});
  assign key_index    = mode ? (4'd15 - n) : n;
  assign subkey_valid = (state == RUN);
  assign busy         = (state == RUN);
  assign done         = done_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: launch on start from IDLE, return after the 16th acceptance.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)   state_next = RUN;
      RUN:     if (last_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // C/D rotation, accepted-count and mode; everything holds without a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_reg <= '0;
      d_reg <= '0;
      n     <= '0;
      mode  <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        mode <= decrypt;
        n    <= '0;
        if (decrypt) begin
          c_reg <= pc1_key[55:28];
          d_reg <= pc1_key[27:0];
        end else begin
          c_reg <= rotl(pc1_key[55:28], 1'b1);
          d_reg <= rotl(pc1_key[27:0], 1'b1);
        end
      end
    end else if (hs) begin
      if (n != 4'd15) begin
        n <= n + 4'd1;
        if (mode) begin
          c_reg <= rotr(c_reg, single_step);
          d_reg <= rotr(d_reg, single_step);
        end else begin
          c_reg <= rotl(c_reg, single_step);
          d_reg <= rotl(d_reg, single_step);
        end
      end else begin
        n <= '0;
      end
    end
  end

  // One-cycle completion pulse following the final acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= last_hs;
  end

endmodule

// File: tb/tb_des_subkey_gen.sv
// tb/tb_des_subkey_gen.sv - scoreboard bench for des_subkey_gen

module tb_des_subkey_gen;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        decrypt;
  logic [63:0] key;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [3:0]  key_index;
  logic        busy;
  logic        done;

  des_subkey_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .decrypt      (decrypt),
    .key          (key),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .key_index    (key_index),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] MAIN_KEY   = 64'h133457799BBCDFF1;
  localparam logic [63:0] PARITY_KEY = 64'h123457799BBCDFF1;

  typedef struct {
    logic [47:0] k;
    logic [3:0]  idx;
  } exp_t;

  exp_t        sb[$];
  logic [47:0] ktab[16];
  int          checks = 0;
  int          errors = 0;
  int          n_done = 0;
  int          n_hs   = 0;

  task automatic push_sched(input bit dec);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.idx = dec ? 4'(15 - i) : 4'(i);
      e.k   = ktab[e.idx];
      sb.push_back(e);
    end
  endtask

  // Called at a negedge; leaves at the negedge after start was sampled.
  task automatic start_sched(input logic [63:0] k, input bit dec, input string tag);
    start   = 1'b1;
    key     = k;
    decrypt = dec;
    @(negedge clk);
    start   = 1'b0;
    key     = {$urandom, $urandom};
    decrypt = ~dec;
    checks++;
    if (subkey_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_first_valid got %b want 1", tag, subkey_valid);
    end
  endtask

  // Scoreboard consumer: pops on each handshake, watches stall stability.
  task automatic run_cycles(input bit rnd, input int stop_hs, input int inject_hs, input string tag);
    int          cyc = 0;
    int          hs  = 0;
    bit          prev_stall = 1'b0;
    logic [47:0] pk = '0;
    logic [3:0]  pi = '0;
    exp_t        e;
    while (sb.size() > 0 && hs < stop_hs && cyc < 400) begin
      subkey_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inject_hs >= 0 && hs == inject_hs) begin
        start   = 1'b1;
        key     = 64'hFEDCBA9876543210;
        decrypt = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) n_done++;
      if (prev_stall) begin
        checks++;
        if (subkey !== pk || key_index !== pi) begin
          errors++;
          $display("FAIL %s_stall_stable got %h/%0d want %h/%0d", tag, subkey, key_index, pk, pi);
        end
      end
      if (subkey_valid === 1'b1 && subkey_ready) begin
        e = sb.pop_front();
        checks++;
        if (subkey !== e.k || key_index !== e.idx) begin
          errors++;
          $display("FAIL %s_subkey got %h/%0d want %h/%0d", tag, subkey, key_index, e.k, e.idx);
        end
        hs++;
        n_hs++;
      end
      prev_stall = (subkey_valid === 1'b1) && !subkey_ready;
      pk = subkey;
      pi = key_index;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    if (cyc >= 400) begin
      errors++;
      $display("FAIL %s_timeout got %0d handshakes want %0d", tag, hs, stop_hs);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    decrypt = 1'b0;
    key = '0;
    subkey_ready = 1'b0;
    #1;
    checks++;
    if (subkey_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got v%b b%b d%b want 000", subkey_valid, busy, done);
    end
    checks++;
    if (subkey !== 48'h0 || key_index !== 4'd0) begin
      errors++;
      $display("FAIL reset_data got %h/%0d want 0/0", subkey, key_index);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_order(input bit dec, input string tag);
    n_done = 0;
    n_hs   = 0;
    push_sched(dec);
    start_sched(MAIN_KEY, dec, tag);
    run_cycles(1'b0, 16, -1, tag);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || subkey_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_cycle got d%b b%b v%b want 100", tag, done, busy, subkey_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || n_hs != 16 || n_done != 0) begin
      errors++;
      $display("FAIL %s_done_pulse got d%b hs%0d extra%0d want 0/16/0", tag, done, n_hs, n_done);
    end
  endtask

  task automatic test_backpressure();
    n_done = 0;
    n_hs   = 0;
    push_sched(1'b0);
    start_sched(MAIN_KEY, 1'b0, "bp");
    run_cycles(1'b1, 16, -1, "bp");
    checks++;
    if (done !== 1'b1 || n_hs != 16 || n_done != 0) begin
      errors++;
      $display("FAIL bp_done got d%b hs%0d extra%0d want 1/16/0", done, n_hs, n_done);
    end
    subkey_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL bp_done_width got %b want 0", done);
    end
  endtask

  task automatic test_busy_start();
    n_done = 0;
    push_sched(1'b0);
    start_sched(MAIN_KEY, 1'b0, "busy");
    run_cycles(1'b0, 16, 5, "busy");
    checks++;
    if (done !== 1'b1 || n_done != 0) begin
      errors++;
      $display("FAIL busy_done got d%b extra%0d want 1/0", done, n_done);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
      checks++;
      if (busy !== 1'b0 || subkey_valid !== 1'b0) begin
        errors++;
        $display("FAIL busy_idle got b%b v%b want 00", busy, subkey_valid);
      end
    end
    checks++;
    if (n_done != 0) begin
      errors++;
      $display("FAIL busy_extra_done got %0d want 0", n_done);
    end
    push_sched(1'b1);
    start_sched(MAIN_KEY, 1'b1, "busy_restart");
    run_cycles(1'b0, 16, -1, "busy_restart");
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    push_sched(1'b0);
    start_sched(MAIN_KEY, 1'b0, "rst");
    run_cycles(1'b0, 7, -1, "rst");
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (subkey_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_async got v%b b%b d%b want 000", subkey_valid, busy, done);
    end
    checks++;
    if (subkey !== 48'h0 || key_index !== 4'd0) begin
      errors++;
      $display("FAIL rst_async_data got %h/%0d want 0/0", subkey, key_index);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_done got %b want 0", done);
    end
    push_sched(1'b0);
    start_sched(MAIN_KEY, 1'b0, "rst_again");
    run_cycles(1'b0, 16, -1, "rst_again");
    @(negedge clk);
  endtask

  task automatic test_parity_restart();
    push_sched(1'b0);
    start_sched(PARITY_KEY, 1'b0, "par");
    run_cycles(1'b0, 16, -1, "par");
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL par_done got %b want 1", done);
    end
    push_sched(1'b0);
    start_sched(MAIN_KEY, 1'b0, "par_restart");
    run_cycles(1'b0, 16, -1, "par_restart");
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL par_restart_done got %b want 1", done);
    end
    @(negedge clk);
  endtask

  initial begin
    ktab[0]  = 48'h1B02EFFC7072;
    ktab[1]  = 48'h79AED9DBC9E5;
    ktab[2]  = 48'h55FC8A42CF99;
    ktab[3]  = 48'h72ADD6DB351D;
    ktab[4]  = 48'h7CEC07EB53A8;
    ktab[5]  = 48'h63A53E507B2F;
    ktab[6]  = 48'hEC84B7F618BC;
    ktab[7]  = 48'hF78A3AC13BFB;
    ktab[8]  = 48'hE0DBEBEDE781;
    ktab[9]  = 48'hB1F347BA464F;
    ktab[10] = 48'h215FD3DED386;
    ktab[11] = 48'h7571F59467E9;
    ktab[12] = 48'h97C5D1FABA41;
    ktab[13] = 48'h5F43B7F2E73A;
    ktab[14] = 48'hBF918D3D3F0A;
    ktab[15] = 48'hCB3D8B0E17F5;

    test_reset();
    test_order(1'b0, "fwd");
    test_order(1'b1, "rev");
    test_backpressure();
    test_busy_start();
    test_reset_mid();
    test_parity_restart();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
